// File: rtl/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Round-robin arbiter and sequencer sharing one memory register-bus port among
// NumReq requesters. Exactly one transaction is in flight at a time:
//   IDLE   -> pick a requester, accept it, latch its fields
//   ACCESS -> present the latched request to memory until mem_ready_i
//   RESP   -> one-cycle response pulse to the owning requester
//
// Handshake rules (valid/ready, both directions):
//   A transfer happens in a cycle where valid and ready are both 1. The
//   initiator holds valid and all payload fields stable until that cycle, and
//   may drop valid only after it. Ready may depend combinationally on valid.
//   Responses (rsp_valid_o) are unconditional one-cycle pulses.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_valid_i/req_ready_o    per-requester handshake (ready one-hot or zero)
//   req_write_i                per-requester write flag
//   req_addr_i/wdata_i/wstrb_i packed per-requester payload (slice i = req i)
//   rsp_valid_o                per-requester response pulse
//   rsp_rdata_o, rsp_error_o   shared response payload (0 when no response)
//   mem_valid_o/mem_ready_i    memory handshake
//   mem_write_o/addr_o/wdata_o/wstrb_o  latched request (addr word-aligned)
//   mem_rdata_i, mem_error_i   memory return, sampled when mem_ready_i=1
//   timeout_o                  (only with TB_MEM_ARB_TIMEOUT_EN) one-cycle pulse
//                              in the last ACCESS cycle of a timed-out access
//
// Optional feature macro: TB_MEM_ARB_TIMEOUT_EN
//   Adds an ACCESS watchdog of TimeoutCycles cycles and the timeout_o port.
// -----------------------------------------------------------------------------
module tb_mem_arbiter #(
    parameter int NumReq        = 2,
    parameter int AddrWidth     = 48,
    parameter int DataWidth     = 64,
    parameter int TimeoutCycles = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumReq-1:0]               req_valid_i,
    output logic [NumReq-1:0]               req_ready_o,
    input  logic [NumReq-1:0]               req_write_i,
    input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
    input  logic [NumReq*DataWidth-1:0]     req_wdata_i,
    input  logic [NumReq*DataWidth/8-1:0]   req_wstrb_i,
    output logic [NumReq-1:0]               rsp_valid_o,
    output logic [DataWidth-1:0]            rsp_rdata_o,
    output logic                            rsp_error_o,
    output logic                            mem_valid_o,
    input  logic                            mem_ready_i,
    output logic                            mem_write_o,
    output logic [AddrWidth-1:0]            mem_addr_o,
    output logic [DataWidth-1:0]            mem_wdata_o,
    output logic [DataWidth/8-1:0]          mem_wstrb_o,
    input  logic [DataWidth-1:0]            mem_rdata_i,
`ifdef TB_MEM_ARB_TIMEOUT_EN
    input  logic                            mem_error_i,
    output logic                            timeout_o
`else
    input  logic                            mem_error_i
`endif
);

    localparam int IdxW  = $clog2(NumReq);
    localparam int StrbW = DataWidth / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [IdxW-1:0]      last_q, idx_q;
    logic                 write_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q, rdata_q;
    logic [StrbW-1:0]     wstrb_q;
    logic                 error_q;

    logic [IdxW-1:0]      grant_idx, cand;
    logic                 grant_found;
    logic                 sel_write;
    logic [AddrWidth-1:0] sel_addr;
    logic [DataWidth-1:0] sel_wdata;
    logic [StrbW-1:0]     sel_wstrb;
    logic                 access_done;
    logic                 timeout_hit;

    // Round-robin search starting just after the last winner, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NumReq; k++) begin
            cand = IdxW'((int'(last_q) + k) % NumReq);
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Payload mux of the winning requester.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (grant_idx == IdxW'(i)) begin
                sel_write = req_write_i[i];
                sel_addr  = req_addr_i[i*AddrWidth +: AddrWidth];
                sel_wdata = req_wdata_i[i*DataWidth +: DataWidth];
                sel_wstrb = req_wstrb_i[i*StrbW +: StrbW];
            end
        end
    end

`ifdef TB_MEM_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt_q;

    // The limit is reached in the ACCESS cycle where cnt_q has counted
    // TimeoutCycles-1 stalled cycles; a ready in that same cycle still wins.
    assign timeout_hit = (state_q == ACCESS) && !mem_ready_i &&
                         (cnt_q == CntW'(TimeoutCycles - 1));
    assign timeout_o   = timeout_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if (state_q == ACCESS && !mem_ready_i && !timeout_hit) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign access_done = mem_ready_i || timeout_hit;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_found) state_d = ACCESS;
            ACCESS:  if (access_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch and response capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q  <= IdxW'(NumReq - 1);
            idx_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            if (state_q == IDLE && grant_found) begin
                idx_q   <= grant_idx;
                last_q  <= grant_idx;
                write_q <= sel_write;
                // Memory is word-addressed: drop the byte offset within a word.
                addr_q  <= sel_addr & ~AddrWidth'(StrbW - 1);
                wdata_q <= sel_wdata;
                wstrb_q <= sel_wstrb;
            end
            if (state_q == ACCESS) begin
                if (mem_ready_i) begin
                    rdata_q <= write_q ? '0 : mem_rdata_i;
                    error_q <= mem_error_i;
                end else if (timeout_hit) begin
                    rdata_q <= '0;
                    error_q <= 1'b1;
                end
            end
        end
    end

    assign req_ready_o = (state_q == IDLE && grant_found) ?
                         ({{(NumReq-1){1'b0}}, 1'b1} << grant_idx) : '0;

    assign mem_valid_o = (state_q == ACCESS);
    assign mem_write_o = write_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wstrb_o = wstrb_q;

    assign rsp_valid_o = (state_q == RESP) ? ({{(NumReq-1){1'b0}}, 1'b1} << idx_q) : '0;
    assign rsp_rdata_o = (state_q == RESP) ? rdata_q : '0;
    assign rsp_error_o = (state_q == RESP) ? error_q : 1'b0;

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tb_mem_arbiter
//
// Directed bench for tb_mem_arbiter (NumReq=2, AddrWidth=48, DataWidth=64).
// Expected responses {rsp_valid, rsp_error, rsp_rdata} are queued when a
// request is granted and popped by a negedge monitor whenever a response
// pulse appears. Outside a pulse the monitor expects rsp_rdata/rsp_error = 0.
// With TB_MEM_ARB_TIMEOUT_EN the DUT is built with TimeoutCycles=8 and the
// watchdog sequence is exercised as well.
// -----------------------------------------------------------------------------
module tb_tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid, req_ready, req_write, rsp_valid;
    logic [95:0]  req_addr;
    logic [127:0] req_wdata;
    logic [15:0]  req_wstrb;
    logic [63:0]  rsp_rdata, mem_wdata, mem_rdata, rdata_drv;
    logic         rsp_error, mem_valid, mem_ready, mem_write, mem_error;
    logic [47:0]  mem_addr;
    logic [7:0]   mem_wstrb;
    logic         auto_rdata;
`ifdef TB_MEM_ARB_TIMEOUT_EN
    logic         timeout;
`endif

    logic [66:0]  exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    // Memory read data: either a directed value or an address-derived pattern.
    assign mem_rdata = auto_rdata ? {16'hA5A5, mem_addr} : rdata_drv;

    always #5 clk = ~clk;

    tb_mem_arbiter #(
        .NumReq(2),
        .AddrWidth(48),
        .DataWidth(64),
`ifdef TB_MEM_ARB_TIMEOUT_EN
        .TimeoutCycles(8)
`else
        .TimeoutCycles(1024)
`endif
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_write_i(req_write),
        .req_addr_i(req_addr),
        .req_wdata_i(req_wdata),
        .req_wstrb_i(req_wstrb),
        .rsp_valid_o(rsp_valid),
        .rsp_rdata_o(rsp_rdata),
        .rsp_error_o(rsp_error),
        .mem_valid_o(mem_valid),
        .mem_ready_i(mem_ready),
        .mem_write_o(mem_write),
        .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_wstrb_o(mem_wstrb),
        .mem_rdata_i(mem_rdata),
`ifdef TB_MEM_ARB_TIMEOUT_EN
        .mem_error_i(mem_error),
        .timeout_o(timeout)
`else
        .mem_error_i(mem_error)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor / scoreboard.
    always @(negedge clk) begin
        logic [66:0] e;
        if (rst_n === 1'b1) begin
            if (rsp_valid !== 2'b00) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", {rsp_valid, rsp_error, rsp_rdata}, 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp", {rsp_valid, rsp_error, rsp_rdata}, e);
                end
            end else begin
                chk("rsp_idle_zero", {rsp_error, rsp_rdata}, 128'd0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        mem_ready = 1'b0; mem_error = 1'b0; auto_rdata = 1'b0; rdata_drv = '0;

        // ---- reset state ----
        tick(); tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_fields", {mem_write, mem_addr, mem_wstrb}, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rsp", {rsp_valid, rsp_error, rsp_rdata}, 0);
        rst_n = 1'b1;
        tick();

        // ---- single read from requester 0 ----
        req_valid = 2'b01; req_write = 2'b00; req_addr[47:0] = 48'h1003;
        mem_ready = 1'b1; rdata_drv = 64'hDEAD_BEEF;
        #1 chk("t1_grant", req_ready, 2'b01);
        exp_q.push_back({2'b01, 1'b0, 64'hDEAD_BEEF});
        tick(); req_valid = 2'b00;
        #1 chk("t1_mem_valid", mem_valid, 1);
        chk("t1_mem_addr", mem_addr, 48'h1000);
        chk("t1_mem_write", mem_write, 0);
        chk("t1_busy_ready", req_ready, 0);
        tick(); mem_ready = 1'b0;
        chk("t1_resp_mem_idle", mem_valid, 0);
        tick();

        // ---- contention from a fresh reset ----
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        auto_rdata = 1'b1; mem_ready = 1'b1; req_write = 2'b00;
        req_addr = {48'h300F, 48'h2005};
        req_valid = 2'b11;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back({2'b01, 1'b0, 64'hA5A5_0000_0000_2000});
            exp_q.push_back({2'b10, 1'b0, 64'hA5A5_0000_0000_3008});
        end
        for (int k = 0; k < 12; k++) begin
            #1 chk($sformatf("rr_grant_%0d", k), req_ready,
                   (k % 3 == 0) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
            if (k < 11) tick();
        end
        req_valid = 2'b00;
        tick();
        auto_rdata = 1'b0; mem_ready = 1'b0;

        // ---- stall on requester 0 write, requester 1 waits ----
        req_valid = 2'b01; req_write = 2'b01; req_addr[47:0] = 48'h4013;
        req_wdata[63:0] = 64'h0123_4567_89AB_CDEF; req_wstrb[7:0] = 8'hF0;
        rdata_drv = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 chk("stall_grant", req_ready, 2'b01);
        exp_q.push_back({2'b01, 1'b0, 64'h0});
        tick(); req_valid = 2'b00;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) tick();
            if (c == 3) begin
                req_valid = 2'b10; req_write = 2'b11; req_addr[95:48] = 48'h5008;
                req_wdata[127:64] = 64'h1122; req_wstrb[15:8] = 8'h03;
            end
            #1 chk("stall_mem_valid", mem_valid, 1);
            chk("stall_fields", {mem_write, mem_addr, mem_wstrb}, {1'b1, 48'h4010, 8'hF0});
            chk("stall_wdata", mem_wdata, 64'h0123_4567_89AB_CDEF);
            chk("stall_busy_ready", req_ready, 0);
        end
        tick(); mem_ready = 1'b1;
        #1 chk("stall_last_valid", mem_valid, 1);
        chk("stall_last_fields", {mem_write, mem_addr, mem_wstrb}, {1'b1, 48'h4010, 8'hF0});
        tick(); mem_ready = 1'b0;
        chk("stall_resp_mem_idle", mem_valid, 0);
        chk("resp_busy_ready", req_ready, 0);
        tick();

        // ---- requester 1 write that returns an error ----
        #1 chk("wait_grant", req_ready, 2'b10);
        exp_q.push_back({2'b10, 1'b1, 64'h0});
        mem_ready = 1'b1; mem_error = 1'b1; rdata_drv = 64'hCAFE;
        tick(); req_valid = 2'b00;
        #1 chk("werr_mem_write", mem_write, 1);
        chk("werr_wdata", mem_wdata, 64'h1122);
        chk("werr_wstrb", mem_wstrb, 8'h03);
        chk("werr_addr", mem_addr, 48'h5008);
        tick(); mem_ready = 1'b0; mem_error = 1'b0;
        tick();

        // ---- reset while requester 0 is in ACCESS ----
        req_valid = 2'b01; req_write = 2'b00; req_addr[47:0] = 48'h6000;
        #1 chk("rst_acc_grant", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        #1 chk("pre_rst_mem_valid", mem_valid, 1);
        #2 rst_n = 1'b0;
        #1 chk("rst_acc_mem_valid", mem_valid, 0);
        chk("rst_acc_mem_fields", {mem_write, mem_addr, mem_wstrb}, 0);
        chk("rst_acc_rsp", {rsp_valid, rsp_error, rsp_rdata}, 0);
        chk("rst_acc_ready", req_ready, 0);
        tick(); tick();
        rst_n = 1'b1; mem_ready = 1'b1; rdata_drv = 64'h1234;
        tick(); tick();
        req_addr = {48'h7108, 48'h7000}; req_valid = 2'b11;
        #1 chk("post_rst_grant", req_ready, 2'b01);
        exp_q.push_back({2'b01, 1'b0, 64'h1234});
        tick(); req_valid = 2'b10;
        tick(); tick();
        #1 chk("post_rst_rr", req_ready, 2'b10);
        exp_q.push_back({2'b10, 1'b0, 64'h1234});
        tick(); req_valid = 2'b00;
        #1 chk("post_rst_addr", mem_addr, 48'h7108);
        tick(); tick();
        mem_ready = 1'b0;

`ifdef TB_MEM_ARB_TIMEOUT_EN
        // ---- watchdog: memory never ready ----
        req_valid = 2'b01; req_write = 2'b00; req_addr[47:0] = 48'h8000;
        rdata_drv = 64'h5555;
        #1 chk("to_grant", req_ready, 2'b01);
        exp_q.push_back({2'b01, 1'b1, 64'h0});
        tick(); req_valid = 2'b00;
        for (int c = 1; c <= 8; c++) begin
            #1 chk("to_mem_valid", mem_valid, 1);
            chk("to_pulse", timeout, (c == 8) ? 1'b1 : 1'b0);
            tick();
        end
        chk("to_resp_mem_idle", mem_valid, 0);
        chk("to_pulse_gone", timeout, 0);
        tick();
        chk("to_back_idle_ready", req_ready, 0);
`endif

        tick(); tick(); tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tb_mem_arbiter.md
Name: tb_mem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one testbench memory register-bus port among NumReq requesters.
- Examples of requesters: multiple AXI-to-reg converters, a DMA model, a preload engine.
- Handles one transaction at a time: accept → memory access → registered response.
- Sits in front of the DPI-backed memory model. Downstream ready may stall arbitrarily.

Parameters:
NumReq, 2, number of requester ports (>=2).
AddrWidth, 48, request/memory address width.
DataWidth, 64, data width; power of two, >=8.
TimeoutCycles, 1024, watchdog limit in ACCESS (used only with the optional feature; >=1).

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
req_valid_i  in  NumReq  per-requester request valid.
req_ready_o  out  NumReq  per-requester accept; one-hot or zero.
req_write_i  in  NumReq  1 = write, 0 = read.
req_addr_i  in  NumReq*AddrWidth  packed request addresses; requester i occupies slice i.
req_wdata_i  in  NumReq*DataWidth  packed write data.
req_wstrb_i  in  NumReq*DataWidth/8  packed byte strobes.
rsp_valid_o  out  NumReq  one-cycle response pulse to the owning requester.
rsp_rdata_o  out  DataWidth  shared response data.
rsp_error_o  out  1  shared response error.
mem_valid_o  out  1  memory request valid.
mem_ready_i  in  1  memory accept.
mem_write_o  out  1  latched write flag.
mem_addr_o  out  AddrWidth  latched address with low log2(DataWidth/8) bits forced to 0.
mem_wdata_o  out  DataWidth  latched write data.
mem_wstrb_o  out  DataWidth/8  latched strobes.
mem_rdata_i  in  DataWidth  read data; valid in the cycle mem_ready_i=1.
mem_error_i  in  1  error; valid in the cycle mem_ready_i=1.

Behaviour:
- Reset (async, rst_ni=0):
  - FSM goes to IDLE.
  - Round-robin pointer last = NumReq-1, so requester 0 wins first.
  - All outputs and latched registers are 0.
  - Reset mid-transaction drops it silently; no response is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req_valid_i is set, pick the first set index searching last+1, last+2, … with wrap modulo NumReq.
  - Assert req_ready_o[idx]=1 combinationally in the same cycle.
  - Latch idx, write, addr, wdata, wstrb; set last=idx; go to ACCESS.
  - If no valid is set, stay in IDLE.
  - req_ready_o=0 in every other state.
- ACCESS:
  - mem_valid_o=1; all mem_* fields come from the latch and stay stable until the handshake.
  - On mem_ready_i=1: latch rdata (forced to 0 for writes) and error; go to RESP.
  - Otherwise hold.
- RESP:
  - rsp_valid_o[idx]=1 for exactly one cycle; rsp_rdata_o and rsp_error_o are driven from the latch.
  - Go to IDLE.
  - rsp_rdata_o and rsp_error_o read 0 whenever rsp_valid_o=0.
- Latency:
  - Accept at cycle T; mem_valid_o at T+1.
  - With mem_ready_i=1 at T+1, rsp_valid_o pulses at T+2.
  - Peak throughput: one transaction per 3 cycles.
- Requester rules:
  - Hold valid and fields stable until ready.
  - Valid may deassert only after acceptance.
  - Only one transaction per requester may be outstanding; a requester re-asserting valid during its own ACCESS/RESP simply waits.
- Fairness: a requester holding valid is granted within NumReq arbitration rounds.
- Simultaneous events:
  - New req_valid_i during ACCESS/RESP is ignored until IDLE.
  - mem_ready_i outside ACCESS is ignored.
  - A mem_error_i write still completes normally with rsp_error_o=1.

Optional Feature:
- Macro TB_MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle without mem_ready_i.
  - When it reaches TimeoutCycles, the FSM leaves ACCESS, drops mem_valid_o, and moves to RESP with rsp_error_o=1 and rsp_rdata_o=0.
  - A one-cycle sticky-free pulse timeout_o (extra 1-bit output port) is raised in that cycle.
  - mem_ready_i arriving in the same cycle as the limit wins as a normal completion.
- Undefined: no counter and no timeout_o port; ACCESS waits indefinitely.

Test Plan:
- Single read: req 0, addr 0x1003, mem_ready_i=1 immediately, mem_rdata_i=0xDEAD_BEEF → mem_addr_o=0x1000 at T+1, rsp_valid_o=2'b01 at T+2 with rdata 0xDEAD_BEEF, error 0.
- Contention: req 0 and req 1 valid continuously from reset, memory always ready → grants alternate 0,1,0,1; each response pulses only on the granted index, every 3 cycles.
- Stall: mem_ready_i held 0 for 5 cycles → mem_valid_o high for 6 cycles with addr/wdata/wstrb unchanged; response 1 cycle after ready.
- Write with error: req 1 write wdata 0x1122, wstrb 0x03, mem_error_i=1 → mem_write_o=1, rsp_valid_o=2'b10, rsp_error_o=1, rsp_rdata_o=0.
- Reset in ACCESS: drop rst_ni while mem_valid_o=1 → all outputs 0 immediately, no rsp_valid_o after release, next grant goes to requester 0.
- With TB_MEM_ARB_TIMEOUT_EN, TimeoutCycles=8, mem_ready_i never asserted → mem_valid_o high 8 cycles, then rsp_error_o=1 with timeout_o pulse; FSM back in IDLE.
